// File: rtl/mem_uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_uart_pkg
// Description : Shared state encoding and constants for the MEM-stage
//               Ram1/UART bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_uart_pkg;

    localparam int          CNT_W            = 3;
    localparam logic [15:0] C_UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] C_UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S_RD   = 4'd1,
        S_WR   = 4'd2,
        S_HOLD = 4'd3,
        U_RD   = 4'd4,
        U_WR   = 4'd5,
        U_WAIT = 4'd6,
        STAT   = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_uart_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_uart_ctrl_if
// Description : Pipeline-side request/response bundle of the MEM controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_uart_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_uart_ctrl_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Reset-to-zero flop chain for one asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/mem_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_uart_ctrl
// Description : Multi-cycle Ram1/UART access controller with wait states,
//               UART strobe timing, blocking UART I/O and a status register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_uart_ctrl
    import mem_uart_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 18,
    parameter int                WAIT_CYCLES    = 1,
    parameter int                STROBE_CYCLES  = 2,
    parameter int                SYNC_STAGES    = 2,
    parameter bit                WR_BLOCKING    = 1'b1,
    parameter logic [DATA_W-1:0] UART_DATA_ADDR = DATA_W'(C_UART_DATA_ADDR),
    parameter logic [DATA_W-1:0] UART_STAT_ADDR = DATA_W'(C_UART_STAT_ADDR)
) (
    input  wire                 clk,
    input  wire                 rst_n,
    mem_uart_ctrl_if.slave      bus,
    output logic                o_ram1_en,
    output logic                o_ram1_oe,
    output logic                o_ram1_we,
    output logic [ADDR_W-1:0]   o_ram1_address,
    inout  wire  [DATA_W-1:0]   io_ram1_data,
    output logic                o_rdn,
    output logic                o_wrn,
    input  wire                 i_data_ready,
    input  wire                 i_tbre,
    input  wire                 i_tsre
);
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_ustrobe, w_ustrobe_next;
    logic [DATA_W-1:0]   r_rdata, w_rdata_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_bus_out;
    logic                w_drive;
    logic                w_req;
    logic                w_dr_s, w_tbre_s, w_tsre_s, w_tx_idle;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dr   (.clk(clk), .rst_n(rst_n), .i_d(i_data_ready), .o_q(w_dr_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_tbre (.clk(clk), .rst_n(rst_n), .i_d(i_tbre),       .o_q(w_tbre_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_tsre (.clk(clk), .rst_n(rst_n), .i_d(i_tsre),       .o_q(w_tsre_s));

    assign w_tx_idle = w_tbre_s & w_tsre_s;
    assign w_req     = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ustrobe <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_ustrobe <= w_ustrobe_next;
            r_rdata   <= w_rdata_next;
            if (r_state == IDLE && w_req) begin
                r_addr  <= ADDR_W'(bus.addr);
                r_wdata <= bus.wdata;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_ustrobe_next = 1'b0;
        w_rdata_next   = r_rdata;
        w_drive        = 1'b0;
        w_bus_out      = r_wdata;
        o_ram1_en      = 1'b1;
        o_ram1_oe      = 1'b1;
        o_ram1_we      = 1'b1;
        o_rdn          = 1'b1;
        o_wrn          = 1'b1;
        bus.ack        = 1'b0;

        case (r_state)
            IDLE: begin
                // Writes win when both requests are raised together.
                if (bus.mem_write) begin
                    if (bus.addr == UART_STAT_ADDR) begin
                        w_next = DONE;
                    end else if (bus.addr == UART_DATA_ADDR) begin
                        w_next     = U_WR;
                        w_cnt_next = CNT_W'(STROBE_CYCLES);
                    end else begin
                        w_next     = S_WR;
                        w_cnt_next = CNT_W'(WAIT_CYCLES);
                    end
                end else if (bus.mem_read) begin
                    if (bus.addr == UART_STAT_ADDR) begin
                        w_next = STAT;
                    end else if (bus.addr == UART_DATA_ADDR) begin
                        w_next     = U_RD;
                        w_cnt_next = CNT_W'(STROBE_CYCLES - 1);
                    end else begin
                        w_next     = S_RD;
                        w_cnt_next = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_RD: begin
                o_ram1_en = 1'b0;
                o_ram1_oe = 1'b0;
                if (r_cnt == '0) begin
                    w_rdata_next = io_ram1_data;
                    w_next       = DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_WR: begin
                o_ram1_en = 1'b0;
                o_ram1_we = 1'b0;
                w_drive   = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                o_ram1_en = 1'b0;
                w_drive   = 1'b1;
                w_next    = DONE;
            end
            U_RD: begin
                // Once the strobe has started it runs to completion even if
                // data_ready drops underneath it.
                if (w_dr_s || r_ustrobe) begin
                    o_rdn          = 1'b0;
                    w_ustrobe_next = 1'b1;
                    if (r_cnt == '0) begin
                        w_rdata_next   = DATA_W'(io_ram1_data[7:0]);
                        w_ustrobe_next = 1'b0;
                        w_next         = DONE;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
            U_WR: begin
                w_drive   = 1'b1;
                w_bus_out = DATA_W'(r_wdata[7:0]);
                if (r_cnt != '0) begin
                    o_wrn      = 1'b0;
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_next = WR_BLOCKING ? U_WAIT : DONE;
                end
            end
            U_WAIT: begin
                if (w_tx_idle) begin
                    w_next = DONE;
                end
            end
            STAT: begin
                w_rdata_next = DATA_W'({w_dr_s, w_tx_idle});
                w_next       = DONE;
            end
            DONE: begin
                bus.ack = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.busy       = rst_n & ((r_state == IDLE && w_req) ||
                                     (r_state != IDLE && r_state != DONE));
    assign bus.rdata      = r_rdata;
    assign o_ram1_address = r_addr;
    assign io_ram1_data   = w_drive ? w_bus_out : {DATA_W{1'bz}};
endmodule
`default_nettype wire

// File: tb/tb_mem_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_uart_ctrl
// Description : Directed self-checking bench for mem_uart_ctrl with a small
//               SRAM model and a UART receive-data driver on the shared bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_uart_ctrl;
    logic        clk;
    logic        rst_n;
    logic        ram1_en, ram1_oe, ram1_we, rdn, wrn;
    logic [17:0] ram1_addr;
    wire  [15:0] ram1_data;
    logic        data_ready, tbre, tsre;
    logic [15:0] sram [0:255];
    logic [15:0] uart_rx_val;
    logic        tb_force_en;
    logic [15:0] tb_force_val;
    int          n_checks;
    int          n_fail;

    mem_uart_ctrl_if #(.DATA_W(16)) bus_if ();

    mem_uart_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus_if),
        .o_ram1_en      (ram1_en),
        .o_ram1_oe      (ram1_oe),
        .o_ram1_we      (ram1_we),
        .o_ram1_address (ram1_addr),
        .io_ram1_data   (ram1_data),
        .o_rdn          (rdn),
        .o_wrn          (wrn),
        .i_data_ready   (data_ready),
        .i_tbre         (tbre),
        .i_tsre         (tsre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram1_data = (!ram1_en && !ram1_oe) ? sram[ram1_addr[7:0]] :
                       (!rdn)                 ? uart_rx_val :
                       (tb_force_en)          ? tb_force_val : 16'hzzzz;

    always @(posedge clk) begin
        if (!ram1_en && !ram1_we) sram[ram1_addr[7:0]] <= ram1_data;
    end

    task automatic idle_inputs();
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        bus_if.addr      = 16'h0000;
        bus_if.wdata     = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_checks++; if ({ram1_en, ram1_oe, ram1_we} !== 3'b111) begin n_fail++; $display("FAIL reset_ram_ctl: got %b want 111", {ram1_en, ram1_oe, ram1_we}); end
        n_checks++; if ({rdn, wrn} !== 2'b11) begin n_fail++; $display("FAIL reset_strobes: got %b want 11", {rdn, wrn}); end
        n_checks++; if (ram1_addr !== 18'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", ram1_addr); end
        n_checks++; if ({bus_if.rdata, bus_if.ack, bus_if.busy} !== 18'h0) begin n_fail++; $display("FAIL reset_outs: rdata %h ack %b busy %b want 0", bus_if.rdata, bus_if.ack, bus_if.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sram_write();
        int we_cnt = 0, busy_cnt = 0, ack_cnt = 0, ack_at = -1;
        logic [15:0] bus_seen = 16'h0;
        logic [17:0] addr_seen = 18'h0;
        @(negedge clk);
        bus_if.mem_write = 1'b1; bus_if.addr = 16'h0040; bus_if.wdata = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram1_we === 1'b0) begin we_cnt++; bus_seen = ram1_data; addr_seen = ram1_addr; end
            if (bus_if.busy === 1'b1) busy_cnt++;
            if (bus_if.ack === 1'b1) begin ack_cnt++; ack_at = i; idle_inputs(); end
        end
        n_checks++; if (we_cnt != 2) begin n_fail++; $display("FAIL swr_we_width: got %0d want 2", we_cnt); end
        n_checks++; if (busy_cnt != 3) begin n_fail++; $display("FAIL swr_busy_width: got %0d want 3", busy_cnt); end
        n_checks++; if (ack_cnt != 1 || ack_at != 3) begin n_fail++; $display("FAIL swr_ack: count %0d at %0d want 1 at 3", ack_cnt, ack_at); end
        n_checks++; if (bus_seen !== 16'h1234 || addr_seen !== 18'h00040) begin n_fail++; $display("FAIL swr_bus: data %h addr %h want 1234 00040", bus_seen, addr_seen); end
        n_checks++; if (sram[8'h40] !== 16'h1234) begin n_fail++; $display("FAIL swr_mem: got %h want 1234", sram[8'h40]); end
    endtask

    task automatic test_sram_read();
        int ack_at = -1, oe_cnt = 0;
        logic [15:0] rd = 16'h0;
        @(negedge clk);
        bus_if.mem_read = 1'b1; bus_if.addr = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram1_oe === 1'b0) oe_cnt++;
            if (bus_if.ack === 1'b1) begin ack_at = i; rd = bus_if.rdata; idle_inputs(); end
        end
        n_checks++; if (ack_at != 2) begin n_fail++; $display("FAIL srd_latency: ack at %0d want 2", ack_at); end
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL srd_data: got %h want 1234", rd); end
        n_checks++; if (oe_cnt != 2) begin n_fail++; $display("FAIL srd_oe_width: got %0d want 2", oe_cnt); end
        n_checks++; if (bus_if.rdata !== 16'h1234) begin n_fail++; $display("FAIL srd_hold: got %h want 1234", bus_if.rdata); end
    endtask

    task automatic test_uart_blocking_read();
        data_ready = 1'b0; uart_rx_val = 16'h77A5;
        @(negedge clk);
        bus_if.mem_read = 1'b1; bus_if.addr = 16'hBF00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (bus_if.busy !== 1'b1 || rdn !== 1'b1) begin n_fail++; $display("FAIL urd_block c%0d: busy %b rdn %b want 1 1", i, bus_if.busy, rdn); end
        end
        data_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rdn !== 1'b1) begin n_fail++; $display("FAIL urd_sync_delay: rdn %b want 1", rdn); end
        @(negedge clk);
        n_checks++; if (rdn !== 1'b0 || ram1_oe !== 1'b1) begin n_fail++; $display("FAIL urd_strobe1: rdn %b oe %b want 0 1", rdn, ram1_oe); end
        @(negedge clk);
        n_checks++; if (rdn !== 1'b0 || ram1_en !== 1'b1) begin n_fail++; $display("FAIL urd_strobe2: rdn %b en %b want 0 1", rdn, ram1_en); end
        @(negedge clk);
        n_checks++; if (rdn !== 1'b1 || bus_if.ack !== 1'b1) begin n_fail++; $display("FAIL urd_done: rdn %b ack %b want 1 1", rdn, bus_if.ack); end
        n_checks++; if (bus_if.rdata !== 16'h00A5) begin n_fail++; $display("FAIL urd_data: got %h want 00a5", bus_if.rdata); end
        idle_inputs(); data_ready = 1'b0;
    endtask

    task automatic test_uart_write();
        int wrn_cnt = 0, bad_bus = 0, ack_seen = 0;
        tbre = 1'b1; tsre = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.mem_write = 1'b1; bus_if.addr = 16'hBF00; bus_if.wdata = 16'h3341;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wrn === 1'b0) begin wrn_cnt++; if (ram1_data !== 16'h0041) bad_bus++; end
            if (bus_if.ack === 1'b1) ack_seen++;
        end
        n_checks++; if (wrn_cnt != 2) begin n_fail++; $display("FAIL uwr_wrn_width: got %0d want 2", wrn_cnt); end
        n_checks++; if (bad_bus != 0) begin n_fail++; $display("FAIL uwr_bus: %0d bad samples want 0", bad_bus); end
        n_checks++; if (ack_seen != 0 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL uwr_blocking: acks %0d busy %b want 0 1", ack_seen, bus_if.busy); end
        tsre = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b1 || bus_if.ack !== 1'b0) begin n_fail++; $display("FAIL uwr_sync_wait: busy %b ack %b want 1 0", bus_if.busy, bus_if.ack); end
        @(negedge clk);
        n_checks++; if (bus_if.ack !== 1'b1 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL uwr_ack: ack %b busy %b want 1 0", bus_if.ack, bus_if.busy); end
        idle_inputs();
    endtask

    task automatic test_status();
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.mem_read = 1'b1; bus_if.addr = 16'hBF01;
        @(negedge clk);
        n_checks++; if (ram1_en !== 1'b1 || rdn !== 1'b1 || bus_if.ack !== 1'b0) begin n_fail++; $display("FAIL stat_c1: en %b rdn %b ack %b want 1 1 0", ram1_en, rdn, bus_if.ack); end
        @(negedge clk);
        n_checks++; if (bus_if.ack !== 1'b1 || bus_if.rdata !== 16'h0002) begin n_fail++; $display("FAIL stat_c2: ack %b rdata %h want 1 0002", bus_if.ack, bus_if.rdata); end
        idle_inputs(); data_ready = 1'b0;
    endtask

    task automatic test_both_requests();
        int we_cnt = 0, oe_cnt = 0, acks = 0;
        logic [15:0] rd = 16'h0;
        @(negedge clk);
        bus_if.mem_write = 1'b1; bus_if.mem_read = 1'b1; bus_if.addr = 16'h0010; bus_if.wdata = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram1_we === 1'b0) we_cnt++;
            if (ram1_oe === 1'b0) oe_cnt++;
            if (bus_if.ack === 1'b1) begin acks++; idle_inputs(); end
        end
        n_checks++; if (we_cnt != 2 || oe_cnt != 0 || acks != 1) begin n_fail++; $display("FAIL both_prio: we %0d oe %0d acks %0d want 2 0 1", we_cnt, oe_cnt, acks); end
        bus_if.mem_read = 1'b1; bus_if.addr = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.ack === 1'b1) begin rd = bus_if.rdata; idle_inputs(); end
        end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL both_readback: got %h want beef", rd); end
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        @(negedge clk);
        bus_if.mem_write = 1'b1; bus_if.addr = 16'h0050; bus_if.wdata = 16'hCAFE;
        @(negedge clk);
        n_checks++; if (ram1_we !== 1'b0) begin n_fail++; $display("FAIL rst_pre_we: got %b want 0", ram1_we); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (ram1_we !== 1'b1 || ram1_en !== 1'b1 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: we %b en %b busy %b want 1 1 0", ram1_we, ram1_en, bus_if.busy); end
        n_checks++; if (bus_if.rdata !== 16'h0 || ram1_addr !== 18'h0) begin n_fail++; $display("FAIL rst_regs: rdata %h addr %h want 0 0", bus_if.rdata, ram1_addr); end
        tb_force_val = 16'h5A5A; tb_force_en = 1'b1;
        #1;
        n_checks++; if (ram1_data !== 16'h5A5A) begin n_fail++; $display("FAIL rst_bus_release: got %h want 5a5a", ram1_data); end
        tb_force_en = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin @(negedge clk); if (bus_if.ack !== 1'b0) acks++; end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus_if.ack !== 1'b0) acks++; end
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rst_no_ack: got %0d acks want 0", acks); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        uart_rx_val = 16'h0; tb_force_en = 1'b0; tb_force_val = 16'h0;
        idle_inputs();
        test_reset();
        test_sram_write();
        test_sram_read();
        test_uart_blocking_read();
        test_uart_write();
        test_status();
        test_both_requests();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
